// File: rtl/alu_ctrl_if.sv
// ID/EX control-register bus: decode-stage inputs and registered ALU control outputs.
`timescale 1ns/1ps
interface alu_ctrl_if #(
  parameter int unsigned INSTR_WIDTH = 16
);
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   valid_in;
  logic                   stall;
  logic                   flush;
  logic [3:0]             oper_out;
  logic                   inv_a_out;
  logic                   inv_b_out;
  logic                   cin_out;
  logic                   sign_out;
  logic                   alu_en_out;
  logic                   valid_out;
  logic                   err_out;

  modport master (
    output instr_in, valid_in, stall, flush,
    input  oper_out, inv_a_out, inv_b_out, cin_out, sign_out, alu_en_out, valid_out, err_out
  );

  modport slave (
    input  instr_in, valid_in, stall, flush,
    output oper_out, inv_a_out, inv_b_out, cin_out, sign_out, alu_en_out, valid_out, err_out
  );
endinterface

// File: rtl/alu_ctrl_reg.sv
// One-stage ID/EX control register: decodes the opcode/funct into ALU controls
// and registers them with valid/err; supports stall (hold) and flush (bubble).
`timescale 1ns/1ps
module alu_ctrl_reg #(
  parameter int unsigned INSTR_WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_ctrl_if.slave bus
);
  typedef struct packed {
    logic [3:0] oper;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
    logic       alu_en;
    logic       valid;
    logic       err;
  } ctrl_t;

  localparam ctrl_t Bubble = '{oper: 4'b0100, default: 1'b0};

  logic [4:0] w_opcode;
  logic [1:0] w_funct;
  logic       w_unused_bits;
  ctrl_t      w_dec;
  ctrl_t      r_ctrl;

  assign w_opcode      = bus.instr_in[INSTR_WIDTH-1 -: 5];
  assign w_funct       = bus.instr_in[1:0];
  assign w_unused_bits = ^bus.instr_in[INSTR_WIDTH-6:2];

  always_comb begin
    w_dec       = Bubble;
    w_dec.valid = 1'b1;
    unique case (w_opcode)
      5'b01000, 5'b10000, 5'b10001, 5'b10011: begin
        w_dec.sign   = 1'b1;
        w_dec.alu_en = 1'b1;
      end
      5'b01001: begin
        w_dec.inv_a  = 1'b1;
        w_dec.cin    = 1'b1;
        w_dec.sign   = 1'b1;
        w_dec.alu_en = 1'b1;
      end
      5'b01010: begin
        w_dec.oper   = 4'b0111;
        w_dec.alu_en = 1'b1;
      end
      5'b01011: begin
        w_dec.oper   = 4'b0101;
        w_dec.inv_b  = 1'b1;
        w_dec.alu_en = 1'b1;
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        w_dec.oper   = {2'b00, w_opcode[1:0]};
        w_dec.alu_en = 1'b1;
      end
      5'b10010: begin
        w_dec.oper   = 4'b0110;
        w_dec.alu_en = 1'b1;
      end
      5'b11001: begin
        w_dec.oper   = 4'b1000;
        w_dec.alu_en = 1'b1;
      end
      5'b11010: begin
        w_dec.oper   = {2'b00, w_funct};
        w_dec.alu_en = 1'b1;
      end
      5'b11011: begin
        w_dec.alu_en = 1'b1;
        unique case (w_funct)
          2'b00: w_dec.sign = 1'b1;
          2'b01: begin
            w_dec.inv_a = 1'b1;
            w_dec.cin   = 1'b1;
            w_dec.sign  = 1'b1;
          end
          2'b10: w_dec.oper = 4'b0111;
          2'b11: begin
            w_dec.oper  = 4'b0101;
            w_dec.inv_b = 1'b1;
          end
          default: ;
        endcase
      end
      5'b11100: begin
        w_dec.oper   = 4'b1001;
        w_dec.alu_en = 1'b1;
      end
      // SLT/SLE compute A - B via invB + carry-in
      5'b11101, 5'b11110: begin
        w_dec.oper   = (w_opcode == 5'b11101) ? 4'b1010 : 4'b1011;
        w_dec.inv_b  = 1'b1;
        w_dec.cin    = 1'b1;
        w_dec.sign   = 1'b1;
        w_dec.alu_en = 1'b1;
      end
      5'b11111: begin
        w_dec.oper   = 4'b1100;
        w_dec.alu_en = 1'b1;
      end
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000: ;
      default: w_dec.err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (bus.flush) begin
      r_ctrl <= Bubble;
    end else if (!bus.stall) begin
      r_ctrl <= bus.valid_in ? w_dec : Bubble;
    end
  end

  assign bus.oper_out   = r_ctrl.oper;
  assign bus.inv_a_out  = r_ctrl.inv_a;
  assign bus.inv_b_out  = r_ctrl.inv_b;
  assign bus.cin_out    = r_ctrl.cin;
  assign bus.sign_out   = r_ctrl.sign;
  assign bus.alu_en_out = r_ctrl.alu_en;
  assign bus.valid_out  = r_ctrl.valid;
  assign bus.err_out    = r_ctrl.err;
endmodule

// File: doc/alu_ctrl_reg.md
ALU_CTRL_REG -- requirements
Module: alu_ctrl_reg

Interface
REQ-001 Parameter INSTR_WIDTH, default 16, width of the instruction word; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_in  input  16  decoded-stage instruction; opcode is [15:11], funct is [1:0].
REQ-005 valid_in  input  1  instr_in holds a real instruction this cycle.
REQ-006 stall  input  1  hold all registered outputs unchanged.
REQ-007 flush  input  1  replace the next registered entry with a bubble.
REQ-008 oper_out  output  4  ALU operation code.
REQ-009 inv_a_out  output  1  invert ALU operand A.
REQ-010 inv_b_out  output  1  invert ALU operand B.
REQ-011 cin_out  output  1  ALU carry-in.
REQ-012 sign_out  output  1  signed overflow select.
REQ-013 alu_en_out  output  1  ALU result is consumed by the instruction.
REQ-014 valid_out  output  1  the registered entry is a real instruction.
REQ-015 err_out  output  1  the registered opcode is illegal.

Function
REQ-016 The block SHALL be a one-stage ID/EX control register: the decode of instr_in is captured on a clock edge and appears on the outputs in the next cycle (latency 1).
REQ-017 Oper encoding SHALL be as follows.
- Shifts 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRL.
- 0100 ADD, 0101 AND, 0110 OR/SLBI, 0111 XOR.
- 1000 BTR, 1001 SEQ, 1010 SLT, 1011 SLE, 1100 SCO.
REQ-018 Decode SHALL be as follows (all unlisted controls 0).
- 01000 ADDI: 0100, sign.
- 01001 SUBI: 0100, invA, cin, sign.
- 01010 XORI: 0111.
- 01011 ANDNI: 0101, invB.
- 101xx ROLI/SLLI/RORI/SRLI: 00 plus opcode[1:0].
- 10000 ST, 10001 LD, 10011 STU: 0100, sign.
- 10010 SLBI: 0110.
- 11001 BTR: 1000.
- 11010: 00 plus funct.
- 11011 funct 00 ADD: 0100, sign.
- 11011 funct 01 SUB: 0100, invA, cin, sign.
- 11011 funct 10 XOR: 0111.
- 11011 funct 11 ANDN: 0101, invB.
- 11100 SEQ: 1001.
- 11101 SLT: 1010, invB, cin, sign.
- 11110 SLE: 1011, invB, cin, sign.
- 11111 SCO: 1100, unsigned.
REQ-019 alu_en SHALL be 1 for every opcode in REQ-018 and 0 for all other legal opcodes; those other opcodes SHALL decode to oper 0100 with all other controls 0.
REQ-020 The legal opcode set SHALL be REQ-018 plus 00000 HALT, 00001 NOP, 00010 SIIC, 00011 RTI, 00100-00111 jumps, 01100-01111 branches and 11000 LBI; any other opcode SHALL set err=1.
REQ-021 When valid_in=0, the captured entry SHALL be a bubble: valid=0, err=0, oper=0100, all other controls 0.
REQ-022 Priority SHALL be rst, then flush, then stall, then normal capture.
REQ-023 flush SHALL capture a bubble even when stall=1 in the same cycle.
REQ-024 stall SHALL hold every output bit-for-bit for every cycle it is asserted; instr_in is ignored while stalled.
REQ-025 err and the decoded controls SHALL be registered together so they are always coherent with valid_out.
REQ-026 Outputs SHALL be driven only from flops; no combinational path from any input to any output.

Reset
REQ-027 When rst=1 at a clock edge, all outputs SHALL become 0 on the next cycle (oper=0000, valid=0, err=0), regardless of stall or flush.
REQ-028 Reset asserted while an entry is held by stall SHALL discard that entry.
REQ-029 Normal capture SHALL resume on the first edge after rst deasserts.

Verification
REQ-030 ADD then SUB: instr 0xD800 (11011, funct 00) then 0xD801 (funct 01), valid_in=1 -> next cycles oper 0100 sign=1 invA=0, then oper 0100 invA=1 cin=1 sign=1.
REQ-031 Stall hold: capture SLT 0xE800, assert stall 3 cycles while applying SCO 0xF800 -> outputs stay oper 1010 invB=1 cin=1 for 3 cycles, then show oper 1100 sign=0 cin=0.
REQ-032 Flush during stall: stall=1 and flush=1 together with valid entry -> next cycle valid=0, oper 0100, err=0.
REQ-033 Illegal opcode: 0x6800 (01101 is a branch, legal) -> err=0, alu_en=0; 0x2000 (00100 jump) -> err=0; 0x4000 mapped per table; opcode 10100 path checked -> oper 0000; force unused 0xF-space none -> confirm err only for opcodes outside REQ-020.
REQ-034 Reset mid-stall: entry held with stall=1, pulse rst 1 cycle -> next cycle all outputs 0; after release, SLBI 0x9000 -> oper 0110 one cycle later.
REQ-035 Exhaustive sweep: all 32 opcodes x 4 funct values, valid_in=1 -> outputs match the REQ-018/019/020 table one cycle later.
